// File: rtl/kbd_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : kbd_event_queue
// Purpose  : Merges key events from NUM_SRC producers into one FIFO that the
//            CPU drains through the ZX-Uno SCANCODE / KBSTATUS registers.
//            Each source has a one-entry holding register feeding a
//            round-robin arbiter. The status register exposes a sticky
//            overflow flag, head-entry tags and a pending flag. The queue is
//            flushed through KBSTATUS, and a one-cycle interrupt pulse is
//            raised when the queue goes from empty to non-empty.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_event_queue #(
  parameter int          NUM_SRC       = 2,
  parameter int          DEPTH_LOG2    = 4,
  parameter logic [7:0]  SCANCODE_ADDR = 8'h04,
  parameter logic [7:0]  KBSTATUS_ADDR = 8'h05
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [8*NUM_SRC-1:0]    src_code,
  input  logic [NUM_SRC-1:0]      src_ext,
  input  logic [NUM_SRC-1:0]      src_rls,
  input  logic [7:0]              zxuno_addr,
  input  logic                    zxuno_regrd,
  input  logic                    zxuno_regwr,
  input  logic [7:0]              din,
  output logic [7:0]              scancode_dout,
  output logic                    oe_scancode,
  output logic [7:0]              kbstatus_dout,
  output logic                    oe_kbstatus,
  output logic                    kb_interrupt,
  output logic [DEPTH_LOG2:0]     fifo_count
);

  localparam int                  C_DEPTH_INT = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH     = C_DEPTH_INT[DEPTH_LOG2:0];
  localparam logic [1:0]          C_LAST_SRC  = 2'(NUM_SRC-1);

  // Entry layout: {src_id[1:0], ext, rls, code[7:0]}
  logic [NUM_SRC-1:0]      hold_full_q;
  logic [11:0]             hold_entry_q [NUM_SRC];
  logic [11:0]             mem_q        [C_DEPTH_INT];
  logic [DEPTH_LOG2-1:0]   rptr_q;
  logic [DEPTH_LOG2-1:0]   wptr_q;
  logic [DEPTH_LOG2:0]     count_q;
  logic [DEPTH_LOG2:0]     count_d;
  logic [1:0]              rr_ptr_q;
  logic                    ovf_q;
  logic                    ovf_d;
  logic                    rd_flag_q;
  logic [7:0]              scancode_q;
  logic [7:0]              kbstatus_q;
  logic [DEPTH_LOG2:0]     fifo_count_q;
  logic                    kb_int_q;

  logic                    flush;
  logic                    ovf_clr;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    push;
  logic [1:0]              grant_idx;
  logic [11:0]             push_entry;
  logic [NUM_SRC-1:0]      drained;
  logic                    drop;
  logic [11:0]             head;
  int                      arb_best;
  int                      arb_dist;
  logic                    w_unused_din;

  assign oe_scancode  = (zxuno_addr == SCANCODE_ADDR) && zxuno_regrd;
  assign oe_kbstatus  = (zxuno_addr == KBSTATUS_ADDR) && zxuno_regrd;
  assign flush        = zxuno_regwr && (zxuno_addr == KBSTATUS_ADDR) && din[0];
  assign ovf_clr      = zxuno_regwr && (zxuno_addr == KBSTATUS_ADDR) && din[7];
  assign w_unused_din = ^din[6:1];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == C_DEPTH);
  assign head       = mem_q[rptr_q];

  // The pop fires on the cycle the CPU read strobe ends, so one read is one pop.
  assign pop = rd_flag_q && !oe_scancode && !fifo_empty && !flush;

  // Round-robin pick: the full hold closest to rr_ptr (in wrap order) wins.
  always_comb begin
    grant_idx = '0;
    arb_best  = NUM_SRC;
    arb_dist  = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      arb_dist = (i + NUM_SRC - int'(rr_ptr_q)) % NUM_SRC;
      if (hold_full_q[i] && (arb_dist < arb_best)) begin
        arb_best  = arb_dist;
        grant_idx = 2'(i);
      end
    end
  end

  // A push needs room, or a slot freed by a pop on the same edge.
  assign push = (|hold_full_q) && (!fifo_full || pop) && !flush;

  // Select the granted hold entry and flag which hold is being drained.
  always_comb begin
    push_entry = '0;
    drained    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == 2'(i)) begin
        push_entry = hold_entry_q[i];
        drained[i] = push;
      end
    end
  end

  // A new event that finds its hold still occupied is lost; a flush discards it anyway.
  assign drop = (|(src_valid & hold_full_q & ~drained)) && !flush;

  // Occupancy and sticky overflow next-state.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Per-source holding registers: capture when empty or drained on this edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst || flush) begin
        hold_full_q[i]  <= 1'b0;
        hold_entry_q[i] <= '0;
      end else if (src_valid[i] && (!hold_full_q[i] || drained[i])) begin
        hold_full_q[i]  <= 1'b1;
        hold_entry_q[i] <= {2'(i), src_ext[i], src_rls[i], src_code[8*i +: 8]};
      end else if (drained[i]) begin
        hold_full_q[i]  <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= push_entry;
    end
  end

  // FIFO pointers, occupancy, arbiter pointer, overflow and read-tracking flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      rr_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      rd_flag_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      rd_flag_q <= oe_scancode;
      if (flush) begin
        rptr_q  <= '0;
        wptr_q  <= '0;
        count_q <= '0;
      end else begin
        count_q <= count_d;
        if (push) begin
          wptr_q   <= wptr_q + 1'b1;
          rr_ptr_q <= (grant_idx == C_LAST_SRC) ? 2'd0 : grant_idx + 2'd1;
        end
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end
  end

  // Registered CPU-visible view of the head entry, occupancy and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      scancode_q   <= '0;
      kbstatus_q   <= '0;
      fifo_count_q <= '0;
      kb_int_q     <= 1'b0;
    end else begin
      scancode_q   <= fifo_empty ? 8'h00 : head[7:0];
      kbstatus_q   <= {ovf_q,
                       fifo_empty ? 2'b00 : head[11:10],
                       2'b00,
                       !fifo_empty && head[8],
                       !fifo_empty && head[9],
                       !fifo_empty};
      fifo_count_q <= count_q;
      kb_int_q     <= !fifo_empty && (fifo_count_q == '0);
    end
  end

  assign scancode_dout = scancode_q;
  assign kbstatus_dout = kbstatus_q;
  assign fifo_count    = fifo_count_q;
  assign kb_interrupt  = kb_int_q;

endmodule
`default_nettype wire
